bit_reverse_pair_buffer: RTL and testbench

//  Upstream feeder for the first radix-2 DIT FFT stage. Accepts complex samples in natural

---
 rtl/fft_pkg.sv | 28 ++
 rtl/bit_rev_index.sv | 14 +
 rtl/bit_reverse_pair_buffer.sv | 134 +++++++++++++
 tb/tb_bit_reverse_pair_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath defaults, complex word type and bit-reverse helper
package fft_pkg;

    localparam int DEF_WORD_SZ  = 32;
    localparam int DEF_WORD_MID = 16;
    localparam int DEF_N_LOG2   = 3;
    localparam int MAX_N_LOG2   = 10;

    // Complex sample as seen by the butterfly and twiddle stages: real half on top
    typedef struct packed {
        logic [DEF_WORD_SZ-DEF_WORD_MID-1:0] re;
        logic [DEF_WORD_MID-1:0]             im;
    } cplx_t;

    // Reverse the low 'width' bits of idx; bits at and above 'width' come back as zero
    function automatic logic [MAX_N_LOG2-1:0] bitrev(input logic [MAX_N_LOG2-1:0] idx,
                                                     input int width);
        logic [MAX_N_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N_LOG2; i++) begin
            if (i < width) begin
                r[i] = idx[4'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_rev_index.sv
// rtl/bit_rev_index.sv - combinational N_LOG2-bit index reversal
module bit_rev_index
    import fft_pkg::*;
#(
    parameter int N_LOG2 = DEF_N_LOG2
) (
    input  logic [N_LOG2-1:0] idx,
    output logic [N_LOG2-1:0] idx_rev
);

    // Pure wiring: reverse the index bits through the shared helper
    assign idx_rev = N_LOG2'(bitrev(MAX_N_LOG2'(idx), N_LOG2));

endmodule

// File: rtl/bit_reverse_pair_buffer.sv
// rtl/bit_reverse_pair_buffer.sv - ping-pong frame buffer emitting bit-reversed (A,B) pairs
module bit_reverse_pair_buffer
    import fft_pkg::*;
#(
    parameter int WORD_SZ  = DEF_WORD_SZ,
    parameter int WORD_MID = DEF_WORD_MID,
    parameter int N_LOG2   = DEF_N_LOG2
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic [WORD_SZ-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [WORD_SZ-1:0] o_A,
    output logic [WORD_SZ-1:0] o_B,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_first,
    output logic               o_last
);

    localparam int N      = 1 << N_LOG2;
    localparam int N_HALF = N / 2;
    // Pair counter keeps at least one bit so N=2 still has a well-formed register
    localparam int PAIR_W = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;

    localparam logic [N_LOG2-1:0] WR_LAST = N_LOG2'(N - 1);
    localparam logic [PAIR_W-1:0] RD_LAST = PAIR_W'(N_HALF - 1);

    // Sample storage is deliberately not reset; the full flags say what is meaningful
    logic [WORD_SZ-1:0] mem_q [2][N];

    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [N_LOG2-1:0] wr_idx_q, wr_idx_d;
    logic [PAIR_W-1:0] rd_pair_q, rd_pair_d;

    logic              wr_fire;
    logic              rd_fire;
    logic              wr_at_last;
    logic              rd_at_last;
    logic [N_LOG2-1:0] addr_even;
    logic [N_LOG2-1:0] addr_odd;
    logic [N_LOG2-1:0] rev_even;
    logic [N_LOG2-1:0] rev_odd;
    logic [WORD_SZ-1:0] a_word;
    logic [WORD_SZ-1:0] b_word;

    assign o_ready    = !full_q[wr_bank_q];
    assign o_valid    = full_q[rd_bank_q];
    assign wr_fire    = i_valid && o_ready;
    assign rd_fire    = o_valid && i_ready;
    assign wr_at_last = (wr_idx_q == WR_LAST);
    assign rd_at_last = (rd_pair_q == RD_LAST);

    // Pair k reads natural positions 2k and 2k+1 through the reversal network
    assign addr_even = N_LOG2'({rd_pair_q, 1'b0});
    assign addr_odd  = N_LOG2'({rd_pair_q, 1'b1});

    bit_rev_index #(.N_LOG2(N_LOG2)) u_rev_even (
        .idx     (addr_even),
        .idx_rev (rev_even)
    );

    bit_rev_index #(.N_LOG2(N_LOG2)) u_rev_odd (
        .idx     (addr_odd),
        .idx_rev (rev_odd)
    );

    assign a_word = mem_q[rd_bank_q][rev_even];
    assign b_word = mem_q[rd_bank_q][rev_odd];

    // Words leave bit-exact; real/imag halves are kept in their fixed positions
    assign o_A = {a_word[WORD_SZ-1:WORD_MID], a_word[WORD_MID-1:0]};
    assign o_B = {b_word[WORD_SZ-1:WORD_MID], b_word[WORD_MID-1:0]};

    assign o_first = o_valid && (rd_pair_q == '0);
    assign o_last  = o_valid && rd_at_last;

    // Next-state for write/read pointers and bank flags; fill and drain touch different banks
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_pair_d = rd_pair_q;

        if (wr_fire) begin
            if (wr_at_last) begin
                wr_idx_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end

        if (rd_fire) begin
            if (rd_at_last) begin
                rd_pair_d         = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_pair_d = rd_pair_q + 1'b1;
            end
        end
    end

    // Control state register with asynchronous clear; partial frames are simply forgotten
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            rd_pair_q <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_pair_q <= rd_pair_d;
        end
    end

    // Bank array write port, natural order into the bank being filled
    always_ff @(posedge i_CLK) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_idx_q] <= i_data;
        end
    end

endmodule

// File: tb/tb_bit_reverse_pair_buffer.sv
// tb/tb_bit_reverse_pair_buffer.sv - directed self-checking bench for bit_reverse_pair_buffer
module tb_bit_reverse_pair_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_data;
    logic        i_valid;
    logic        i_ready;
    logic        o_ready;
    logic [31:0] o_A;
    logic [31:0] o_B;
    logic        o_valid;
    logic        o_first;
    logic        o_last;

    logic [31:0] d1_data;
    logic        d1_valid;
    logic        d1_ready;
    logic        q1_ready;
    logic [31:0] q1_A;
    logic [31:0] q1_B;
    logic        q1_valid;
    logic        q1_first;
    logic        q1_last;

    int checks = 0;
    int errors = 0;
    int ea [4] = '{0, 2, 1, 3};
    int eb [4] = '{4, 6, 5, 7};

    always #5 clk = ~clk;

    bit_reverse_pair_buffer #(.WORD_SZ(32), .WORD_MID(16), .N_LOG2(3)) dut (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_A     (o_A),
        .o_B     (o_B),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_first (o_first),
        .o_last  (o_last)
    );

    bit_reverse_pair_buffer #(.WORD_SZ(32), .WORD_MID(16), .N_LOG2(1)) dut1 (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_data  (d1_data),
        .i_valid (d1_valid),
        .o_ready (q1_ready),
        .o_A     (q1_A),
        .o_B     (q1_B),
        .o_valid (q1_valid),
        .i_ready (d1_ready),
        .o_first (q1_first),
        .o_last  (q1_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_frame(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            i_data  = 32'(base + i);
            i_valid = 1'b1;
            chk("wr_ready", 32'(o_ready), 32'd1);
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic chk_pair(input int base, input int k);
        chk("pair_valid", 32'(o_valid), 32'd1);
        chk("pair_A", o_A, 32'(base + ea[k]));
        chk("pair_B", o_B, 32'(base + eb[k]));
        chk("pair_first", 32'(o_first), 32'(k == 0));
        chk("pair_last", 32'(o_last), 32'(k == 3));
    endtask

    task automatic drain(input int base, input bit stall, input int npairs);
        for (int k = 0; k < npairs; k++) begin
            if (stall) begin
                i_ready = 1'b0;
                chk_pair(base, k);
                tick();
                chk_pair(base, k);
            end
            i_ready = 1'b1;
            chk_pair(base, k);
            tick();
        end
        i_ready = 1'b0;
    endtask

    initial begin
        int f;
        int k;
        bit v;

        rst      = 1'b1;
        i_data   = '0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        d1_data  = '0;
        d1_valid = 1'b0;
        d1_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_first", 32'(o_first), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        rst = 1'b0;
        tick();

        // Scenario 1: single frame, latency and pair order
        write_frame(0, 7);
        chk("s1_valid_before_last", 32'(o_valid), 32'd0);
        write_frame(7, 1);
        chk("s1_valid_latency", 32'(o_valid), 32'd1);
        drain(0, 1'b0, 4);
        chk("s1_valid_after", 32'(o_valid), 32'd0);

        // Scenario 2: three frames streamed with no gaps
        i_ready = 1'b1;
        for (int c = 0; c < 28; c++) begin
            i_valid = (c < 24);
            i_data  = 32'(c);
            v = (c >= 8) && ((c % 8) < 4);
            chk("s2_ready", 32'(o_ready), 32'd1);
            chk("s2_valid", 32'(o_valid), 32'(v));
            if (v) begin
                f = c / 8 - 1;
                k = c % 8;
                chk("s2_A", o_A, 32'(8 * f + ea[k]));
                chk("s2_B", o_B, 32'(8 * f + eb[k]));
                chk("s2_first", 32'(o_first), 32'(k == 0));
                chk("s2_last", 32'(o_last), 32'(k == 3));
            end
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("s2_valid_after", 32'(o_valid), 32'd0);

        // Scenario 4: downstream stalls on every pair
        write_frame(0, 8);
        drain(0, 1'b1, 4);
        chk("s4_valid_after", 32'(o_valid), 32'd0);

        // Scenario 3: both banks full, input backpressured until a bank drains
        write_frame(100, 16);
        chk("s3_ready_full", 32'(o_ready), 32'd0);
        i_data  = 32'd116;
        i_valid = 1'b1;
        tick();
        tick();
        chk("s3_ready_held", 32'(o_ready), 32'd0);
        chk("s3_valid_held", 32'(o_valid), 32'd1);
        chk("s3_A_held", o_A, 32'd100);
        i_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("s3_ready_draining", 32'(o_ready), 32'd0);
            chk("s3_A", o_A, 32'(100 + ea[j]));
            chk("s3_B", o_B, 32'(100 + eb[j]));
            tick();
        end
        i_ready = 1'b0;
        chk("s3_ready_back", 32'(o_ready), 32'd1);
        chk("s3_next_A", o_A, 32'd108);
        tick();
        i_valid = 1'b0;
        drain(108, 1'b0, 4);
        write_frame(117, 7);
        drain(116, 1'b0, 4);
        chk("s3_valid_after", 32'(o_valid), 32'd0);

        // Scenario 5: reset during fill and during drain
        write_frame(200, 5);
        rst = 1'b1;
        #1;
        chk("s5_fill_rst_valid", 32'(o_valid), 32'd0);
        chk("s5_fill_rst_ready", 32'(o_ready), 32'd1);
        tick();
        rst = 1'b0;
        write_frame(50, 8);
        drain(50, 1'b0, 2);
        chk("s5_pre_rst_valid", 32'(o_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("s5_drain_rst_valid", 32'(o_valid), 32'd0);
        chk("s5_drain_rst_ready", 32'(o_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("s5_no_stale", 32'(o_valid), 32'd0);
        write_frame(0, 8);
        drain(0, 1'b0, 4);
        chk("s5_valid_after", 32'(o_valid), 32'd0);

        // Scenario 6: two-point frame on the N=2 instance
        d1_valid = 1'b1;
        d1_data  = 32'hAAAA5555;
        tick();
        d1_data  = 32'h12345678;
        tick();
        d1_valid = 1'b0;
        chk("s6_valid", 32'(q1_valid), 32'd1);
        chk("s6_A", q1_A, 32'hAAAA5555);
        chk("s6_B", q1_B, 32'h12345678);
        chk("s6_first", 32'(q1_first), 32'd1);
        chk("s6_last", 32'(q1_last), 32'd1);
        chk("s6_ready", 32'(q1_ready), 32'd1);
        d1_ready = 1'b1;
        tick();
        d1_ready = 1'b0;
        chk("s6_valid_after", 32'(q1_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
